// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and the round-robin search used by the PCIe TX arbiter.
// rr_next scans upward from last+1, wrapping, and returns the first requester.
package pcie_tx_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_CH   = 16;
  localparam int MAX_CH_W = 4;
  localparam int IDX_W    = MAX_CH_W + 1;

  function automatic logic [MAX_CH_W-1:0] rr_next(
    input logic [MAX_CH-1:0]   req,
    input logic [MAX_CH_W-1:0] last,
    input int                  num_ch
  );
    logic [MAX_CH_W-1:0] pick;
    logic                found;
    logic [IDX_W-1:0]    idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = {1'b0, last} + IDX_W'(i);
      if (idx >= IDX_W'(num_ch)) idx = idx - IDX_W'(num_ch);
      if (!found && (i <= num_ch) && req[idx[MAX_CH_W-1:0]]) begin
        pick  = idx[MAX_CH_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pcie_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder over NUM_CH request lines.
module rr_pick
  import pcie_tx_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_last,
  output logic [CH_W-1:0]   o_pick,
  output logic              o_any
);

  assign o_pick = CH_W'(rr_next(MAX_CH'(i_req), MAX_CH_W'(i_last), NUM_CH));
  assign o_any  = |i_req;

endmodule

// File: rtl/pcie_tx_arbiter.sv
// N-channel AXI4-Stream TX arbiter: round-robin grants that only move on TLP
// boundaries, with an optional per-grant packet quota.
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int NUM_CH       = 4,
  parameter int CH_W         = $clog2(NUM_CH),
  parameter int MAX_PKTS     = 0,
  parameter int TCQ          = 1
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic                         s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0]      s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]        s_axis_tx_tkeep,
  output logic                         s_axis_tx_tlast,
  output logic                         s_axis_tx_tvalid,
  output logic                         tx_src_dsc,
  input  logic [NUM_CH-1:0]            s_axis_txc_req,
  output logic [NUM_CH-1:0]            s_axis_txc_ack,
  output logic [NUM_CH-1:0]            s_axis_txc_tready,
  input  logic [NUM_CH*C_DATA_WIDTH-1:0] s_axis_txc_tdata,
  input  logic [NUM_CH*KEEP_WIDTH-1:0] s_axis_txc_tkeep,
  input  logic [NUM_CH-1:0]            s_axis_txc_tlast,
  input  logic [NUM_CH-1:0]            s_axis_txc_tvalid,
  input  logic [NUM_CH-1:0]            txc_src_dsc,
  output logic                         grant_valid,
  output logic [CH_W-1:0]              grant_id
);

  localparam int CNT_W = (MAX_PKTS > 0) ? $clog2(MAX_PKTS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKTS);

  if (NUM_CH < 2 || NUM_CH > MAX_CH || TCQ < 0) begin : g_bad_param
    $error("pcie_tx_arbiter: unsupported parameter set");
  end

  arb_state_t        r_state;
  logic [CH_W-1:0]   r_grant_id;
  logic [CH_W-1:0]   r_last;
  logic              r_in_pkt;
  logic [CNT_W-1:0]  r_pkt_cnt;
  logic [NUM_CH-1:0] r_ack;

  logic              w_acc;
  logic              w_acc_mid;
  logic              w_acc_last;
  logic [NUM_CH-1:0] w_others;
  logic [CH_W-1:0]   w_base;
  logic [CH_W-1:0]   w_pick;
  logic              w_any_other;
  logic              w_req_g;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_quota;
  logic              w_release;

  assign w_acc      = s_axis_tx_tvalid & s_axis_tx_tready;
  assign w_acc_mid  = w_acc & ~s_axis_tx_tlast;
  assign w_acc_last = w_acc & s_axis_tx_tlast;

  // The current holder is masked out and the search starts just past it, so
  // it can only regain the port when nobody else is asking.
  assign w_others = s_axis_txc_req & ~r_ack;
  assign w_base   = (r_state == ST_GRANT) ? r_grant_id : r_last;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .i_req  (w_others),
    .i_last (w_base),
    .o_pick (w_pick),
    .o_any  (w_any_other)
  );

  assign w_req_g    = |(s_axis_txc_req & r_ack);
  assign w_cnt_next = (w_acc_last && (r_pkt_cnt < CNT_MAX)) ? r_pkt_cnt + 1'b1 : r_pkt_cnt;
  // The quota counts the TLP finishing this cycle so the yield lands on its edge.
  assign w_quota    = (MAX_PKTS != 0) && (w_cnt_next >= CNT_MAX) && w_any_other;
  assign w_release  = (r_state == ST_GRANT) && !r_in_pkt && !w_acc_mid &&
                      (!w_req_g || w_quota);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_last     <= '0;
      r_in_pkt   <= 1'b0;
      r_pkt_cnt  <= '0;
      r_ack      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_other) begin
            r_state    <= ST_GRANT;
            r_grant_id <= w_pick;
            r_ack      <= NUM_CH'(1) << w_pick;
            r_pkt_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          if (w_acc_mid) r_in_pkt <= 1'b1;
          else if (w_acc_last) r_in_pkt <= 1'b0;
          if (w_release) begin
            r_last    <= r_grant_id;
            r_pkt_cnt <= '0;
            if (w_any_other) begin
              r_grant_id <= w_pick;
              r_ack      <= NUM_CH'(1) << w_pick;
            end else begin
              r_state    <= ST_IDLE;
              r_grant_id <= '0;
              r_ack      <= '0;
            end
          end else begin
            r_pkt_cnt <= w_cnt_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_txc_ack    = r_ack;
  assign grant_valid       = (r_state == ST_GRANT);
  assign grant_id          = r_grant_id;
  assign s_axis_txc_tready = {NUM_CH{s_axis_tx_tready}} & r_ack;

  always_comb begin
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    tx_src_dsc       = 1'b0;
    if (grant_valid) begin
      s_axis_tx_tdata  = s_axis_txc_tdata[int'(r_grant_id)*C_DATA_WIDTH +: C_DATA_WIDTH];
      s_axis_tx_tkeep  = s_axis_txc_tkeep[int'(r_grant_id)*KEEP_WIDTH +: KEEP_WIDTH];
      s_axis_tx_tlast  = s_axis_txc_tlast[r_grant_id];
      s_axis_tx_tvalid = s_axis_txc_tvalid[r_grant_id];
      tx_src_dsc       = txc_src_dsc[r_grant_id];
    end
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Scoreboard bench for pcie_tx_arbiter: sources driven from TLP plans, a
// rule-level arbitration model predicts acks and beats, a monitor compares.
module tb_pcie_tx_arbiter;

  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam int MAXP = 2;

  logic              clk = 1'b0;
  logic              sys_rst;
  logic              s_axis_tx_tready;
  logic [DW-1:0]     s_axis_tx_tdata;
  logic [KW-1:0]     s_axis_tx_tkeep;
  logic              s_axis_tx_tlast;
  logic              s_axis_tx_tvalid;
  logic              tx_src_dsc;
  logic [NCH-1:0]    s_axis_txc_req;
  logic [NCH-1:0]    s_axis_txc_ack;
  logic [NCH-1:0]    s_axis_txc_tready;
  logic [NCH*DW-1:0] s_axis_txc_tdata;
  logic [NCH*KW-1:0] s_axis_txc_tkeep;
  logic [NCH-1:0]    s_axis_txc_tlast;
  logic [NCH-1:0]    s_axis_txc_tvalid;
  logic [NCH-1:0]    txc_src_dsc;
  logic              grant_valid;
  logic [CHW-1:0]    grant_id;

  pcie_tx_arbiter #(
    .C_DATA_WIDTH (DW),
    .KEEP_WIDTH   (KW),
    .NUM_CH       (NCH),
    .CH_W         (CHW),
    .MAX_PKTS     (MAXP),
    .TCQ          (1)
  ) dut (
    .clk               (clk),
    .sys_rst           (sys_rst),
    .s_axis_tx_tready  (s_axis_tx_tready),
    .s_axis_tx_tdata   (s_axis_tx_tdata),
    .s_axis_tx_tkeep   (s_axis_tx_tkeep),
    .s_axis_tx_tlast   (s_axis_tx_tlast),
    .s_axis_tx_tvalid  (s_axis_tx_tvalid),
    .tx_src_dsc        (tx_src_dsc),
    .s_axis_txc_req    (s_axis_txc_req),
    .s_axis_txc_ack    (s_axis_txc_ack),
    .s_axis_txc_tready (s_axis_txc_tready),
    .s_axis_txc_tdata  (s_axis_txc_tdata),
    .s_axis_txc_tkeep  (s_axis_txc_tkeep),
    .s_axis_txc_tlast  (s_axis_txc_tlast),
    .s_axis_txc_tvalid (s_axis_txc_tvalid),
    .txc_src_dsc       (txc_src_dsc),
    .grant_valid       (grant_valid),
    .grant_id          (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          dsc;
  } beat_t;

  beat_t          beat_q[$];
  logic [NCH-1:0] ack_q[$];
  int             n_checks = 0;
  int             n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // Reference model: one grant holder at a time, moves only between TLPs.
  int m_g, m_last, m_inpkt, m_cnt;

  function automatic int rr_from(input int start, input int excl);
    int ch;
    for (int k = 1; k <= NCH; k++) begin
      ch = (start + k) % NCH;
      if (ch != excl && s_axis_txc_req[ch]) return ch;
    end
    return -1;
  endfunction

  initial begin : model
    int    other, cnt_n;
    bit    acc, acc_last, acc_mid, quota, rel;
    beat_t b;
    m_g = -1; m_last = 0; m_inpkt = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        m_g = -1; m_last = 0; m_inpkt = 0; m_cnt = 0;
        beat_q.delete();
        ack_q.delete();
      end else begin
        ack_q.push_back((m_g < 0) ? '0 : (NCH'(1) << m_g));
        acc = (m_g >= 0) && s_axis_tx_tready && s_axis_txc_tvalid[m_g];
        acc_last = acc && s_axis_txc_tlast[m_g];
        acc_mid  = acc && !s_axis_txc_tlast[m_g];
        if (acc) begin
          b.data = s_axis_txc_tdata[m_g*DW +: DW];
          b.keep = s_axis_txc_tkeep[m_g*KW +: KW];
          b.last = s_axis_txc_tlast[m_g];
          b.dsc  = txc_src_dsc[m_g];
          beat_q.push_back(b);
        end
        if (m_g < 0) begin
          m_g   = rr_from(m_last, -1);
          m_cnt = 0;
        end else begin
          cnt_n = m_cnt + (acc_last ? 1 : 0);
          if (MAXP != 0 && cnt_n > MAXP) cnt_n = MAXP;
          other = rr_from(m_g, m_g);
          quota = (MAXP != 0) && (cnt_n >= MAXP) && (other >= 0);
          rel   = !m_inpkt && !acc_mid && (!s_axis_txc_req[m_g] || quota);
          if (acc_mid) m_inpkt = 1;
          else if (acc_last) m_inpkt = 0;
          if (rel) begin
            m_last = m_g;
            m_g    = other;
            m_cnt  = 0;
          end else begin
            m_cnt = cnt_n;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [NCH-1:0] ea;
    int             eidx;
    beat_t          b;
    forever begin
      @(negedge clk);
      #2;
      if (!sys_rst) begin
        if (ack_q.size() == 0) begin
          check("ack_queue_size", ack_q.size(), 1);
        end else begin
          ea = ack_q.pop_front();
          eidx = 0;
          for (int k = 0; k < NCH; k++) if (ea[k]) eidx = k;
          check("ack", s_axis_txc_ack, ea);
          check("txc_tready", s_axis_txc_tready, ea & {NCH{s_axis_tx_tready}});
          check("grant_valid", grant_valid, |ea);
          if (|ea) check("grant_id", grant_id, eidx);
          else check("idle_outputs", {s_axis_tx_tvalid, s_axis_tx_tlast, tx_src_dsc,
                                      s_axis_tx_tkeep, s_axis_tx_tdata}, '0);
        end
        if (s_axis_tx_tvalid && s_axis_tx_tready) begin
          if (beat_q.size() == 0) begin
            check("beat_queue_size", beat_q.size(), 1);
          end else begin
            b = beat_q.pop_front();
            check("beat", {s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, tx_src_dsc},
                  {b.data, b.keep, b.last, b.dsc});
          end
        end else if (beat_q.size() != 0) begin
          b = beat_q.pop_front();
          check("missing_beat", {s_axis_tx_tvalid, s_axis_tx_tready}, 2'b11);
        end
      end
    end
  end

  // Source plans, only touched by the stimulus process below.
  int            tlps_left[NCH], len[NCH], bidx[NCH], fixlen[NCH], serial[NCH];
  bit            dropped[NCH], drop_plan[NCH], cur_dsc[NCH];
  logic [DW-1:0] cur_data[NCH];
  logic [KW-1:0] cur_keep[NCH];
  int            tr_mode;
  bit            bubbles;

  task automatic new_beat(input int c);
    cur_data[c] = {8'(c), 8'(serial[c]), 16'(bidx[c]), 32'($urandom)};
    cur_keep[c] = 8'($urandom);
  endtask

  task automatic new_tlp(input int c);
    len[c]     = (fixlen[c] != 0) ? fixlen[c] : int'($urandom_range(1, 5));
    bidx[c]    = 0;
    serial[c]++;
    cur_dsc[c] = ($urandom_range(0, 7) == 0);
    new_beat(c);
  endtask

  task automatic drive(input logic [NCH-1:0] acc);
    for (int c = 0; c < NCH; c++) begin
      s_axis_txc_req[c] = (tlps_left[c] > 0) && !dropped[c];
      if (tlps_left[c] > 0) begin
        if (s_axis_txc_tvalid[c] && !acc[c]) s_axis_txc_tvalid[c] = 1'b1;
        else s_axis_txc_tvalid[c] = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_axis_txc_tlast[c]        = (bidx[c] == len[c] - 1);
        s_axis_txc_tdata[c*DW +: DW] = cur_data[c];
        s_axis_txc_tkeep[c*KW +: KW] = cur_keep[c];
        txc_src_dsc[c]             = cur_dsc[c];
      end else begin
        s_axis_txc_tvalid[c]       = 1'b0;
        s_axis_txc_tlast[c]        = 1'b0;
        s_axis_txc_tdata[c*DW +: DW] = '0;
        s_axis_txc_tkeep[c*KW +: KW] = '0;
        txc_src_dsc[c]             = 1'b0;
      end
    end
    case (tr_mode)
      0:       s_axis_tx_tready = 1'b1;
      1:       s_axis_tx_tready = ~s_axis_tx_tready;
      default: s_axis_tx_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic start(input int c, input int n, input int l, input bit drop);
    tlps_left[c] = n;
    fixlen[c]    = l;
    dropped[c]   = 1'b0;
    drop_plan[c] = drop;
    new_tlp(c);
    drive('0);
  endtask

  task automatic step();
    logic [NCH-1:0] acc;
    @(negedge clk);
    acc = s_axis_txc_tready & s_axis_txc_tvalid;
    @(posedge clk);
    #1;
    if (!sys_rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (acc[c]) begin
          if (bidx[c] == len[c] - 1) begin
            tlps_left[c]--;
            if (tlps_left[c] > 0) new_tlp(c);
          end else begin
            bidx[c]++;
            if (drop_plan[c] && tlps_left[c] == 1) dropped[c] = 1'b1;
            new_beat(c);
          end
        end
      end
    end
    drive(acc);
  endtask

  function automatic bit busy();
    for (int c = 0; c < NCH; c++) if (tlps_left[c] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while (busy() && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_timeout", busy(), 1'b0);
    repeat (4) step();
  endtask

  initial begin : stimulus
    sys_rst = 1'b1;
    s_axis_tx_tready = 1'b0;
    s_axis_txc_req = '0; s_axis_txc_tvalid = '0; s_axis_txc_tlast = '0;
    s_axis_txc_tdata = '0; s_axis_txc_tkeep = '0; txc_src_dsc = '0;
    tr_mode = 0; bubbles = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      tlps_left[c] = 0; len[c] = 1; bidx[c] = 0; fixlen[c] = 0; serial[c] = 0;
      dropped[c] = 1'b0; drop_plan[c] = 1'b0; cur_dsc[c] = 1'b0;
      cur_data[c] = '0; cur_keep[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", s_axis_txc_ack, '0);
    check("rst_grant_valid", grant_valid, 1'b0);
    check("rst_grant_id", grant_id, '0);
    check("rst_tvalid", s_axis_tx_tvalid, 1'b0);
    check("rst_tdata", s_axis_tx_tdata, '0);
    drive('0);
    sys_rst = 1'b0;

    start(0, 1, 3, 1'b0);                         // single 3-beat TLP on ch0
    run_until_idle(100);
    for (int c = 0; c < NCH; c++) start(c, 1, 2, 1'b0);
    run_until_idle(100);
    start(2, 1, 4, 1'b1);                         // ch2 drops req mid-TLP
    run_until_idle(100);
    start(0, 5, 1, 1'b0);                         // quota: ch0 yields to ch3
    step(); step();
    start(3, 1, 2, 1'b0);
    run_until_idle(200);
    tr_mode = 1;
    start(1, 1, 4, 1'b0);
    run_until_idle(100);
    tr_mode = 0;

    start(0, 1, 8, 1'b0);
    start(1, 1, 8, 1'b0);
    repeat (4) step();
    check("pre_reset_grant", grant_valid, 1'b1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("async_rst_ack", s_axis_txc_ack, '0);
    check("async_rst_tvalid", s_axis_tx_tvalid, 1'b0);
    check("async_rst_grant_valid", grant_valid, 1'b0);
    for (int c = 0; c < NCH; c++) tlps_left[c] = 0;
    drive('0);
    step(); step();
    sys_rst = 1'b0;
    for (int c = 0; c < NCH; c++) start(c, 1, 2, 1'b0);
    run_until_idle(100);

    bubbles = 1'b1;
    tr_mode = 2;
    repeat (1500) begin
      for (int c = 0; c < NCH; c++)
        if (tlps_left[c] == 0 && $urandom_range(0, 7) == 0)
          start(c, $urandom_range(1, 3), 0, ($urandom_range(0, 3) == 0));
      step();
    end
    tr_mode = 0;
    bubbles = 1'b0;
    run_until_idle(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Parametrised N-channel transmit arbiter for the PCIe endpoint AXI4-Stream TX path. Any number of TLP sources request the shared `s_axis_tx_*` port via a req/ack handshake. The arbiter grants one source at a time with round-robin priority and switches only on TLP boundaries. An optional packet quota forces a busy source to yield to waiting sources.

## Interface
Parameters:
- `C_DATA_WIDTH`, 64: AXIS data width.
- `KEEP_WIDTH`, `C_DATA_WIDTH/8`: tkeep width.
- `NUM_CH`, 4: number of input channels, 2..16.
- `CH_W`, `$clog2(NUM_CH)`: channel index width.
- `MAX_PKTS`, 0: TLPs per grant before forced yield; 0 disables the quota.
- `TCQ`, 1: clock-to-out delay used in simulation.

Ports:
- `clk`, in, 1: core clock.
- `sys_rst`, in, 1: reset, asynchronous, active-high.
- `s_axis_tx_tready`, in, 1: downstream ready.
- `s_axis_tx_tdata`, out, `C_DATA_WIDTH`: muxed data.
- `s_axis_tx_tkeep`, out, `KEEP_WIDTH`: muxed keep.
- `s_axis_tx_tlast`, out, 1: muxed last.
- `s_axis_tx_tvalid`, out, 1: muxed valid.
- `tx_src_dsc`, out, 1: muxed source discontinue.
- `s_axis_txc_req`, in, `NUM_CH`: per-channel request.
- `s_axis_txc_ack`, out, `NUM_CH`: per-channel grant, registered, one-hot or zero.
- `s_axis_txc_tready`, out, `NUM_CH`: per-channel ready.
- `s_axis_txc_tdata`, in, `NUM_CH*C_DATA_WIDTH`: channel c occupies slice `[c*C_DATA_WIDTH +: C_DATA_WIDTH]`.
- `s_axis_txc_tkeep`, in, `NUM_CH*KEEP_WIDTH`: per-channel keep, same slicing.
- `s_axis_txc_tlast`, in, `NUM_CH`: per-channel last.
- `s_axis_txc_tvalid`, in, `NUM_CH`: per-channel valid.
- `txc_src_dsc`, in, `NUM_CH`: per-channel discontinue.
- `grant_valid`, out, 1: a grant is active.
- `grant_id`, out, `CH_W`: index of the granted channel.

## Operation
- **Beat acceptance:** a beat is accepted when `s_axis_tx_tvalid & s_axis_tx_tready`.
- **States:**
  - IDLE: no ack asserted.
  - GRANT(g): `ack[g]=1`.
- **IDLE → GRANT(g):** taken when any req is high. g is the first requesting channel searching upward, wrapping, from `last+1`. `last` is the most recently granted channel, 0 after reset, so channel 1 wins first when all request.
- **In-packet flag `in_pkt`:**
  - Set on an accepted beat with tlast=0.
  - Cleared on an accepted beat with tlast=1.
- **Release condition:** `in_pkt=0` and no beat with tlast=0 accepted this cycle, and either:
  - `req[g]=0`, or
  - the quota is hit: `MAX_PKTS≠0`, `pkt_cnt≥MAX_PKTS`, and some other req is high.
- **On release:**
  - Set `last=g`.
  - If any other channel requests, move directly to GRANT(next) in the same edge, with no idle cycle.
  - Otherwise go to IDLE.
- **req dropped mid-packet:** the grant is held until the tlast beat is accepted, then released. A discontinue TLP still ends with tlast.
- **Quota-forced release:** the source sees ack fall while req is still high. It keeps req asserted and waits for its next round-robin turn.
- **`pkt_cnt`:**
  - Zeroed on every new grant.
  - Increments on each accepted tlast beat.
  - Saturates at `MAX_PKTS`.
  - Width is `$clog2(MAX_PKTS+1)`, minimum 1.
- **Datapath (combinational from registered grant):**
  - `tready[c] = s_axis_tx_tready & ack[c]`.
  - Outputs select channel `grant_id` when `grant_valid`.
  - When not granted: tvalid, tlast, tdata, tkeep and `tx_src_dsc` are all 0.

## Timing
- **Reset:** IDLE. `s_axis_txc_ack=0`, `grant_valid=0`, `grant_id=0`, `last=0`, `in_pkt=0`, `pkt_cnt=0`. Muxed outputs are therefore 0.
- **Grant latency:** req rising in IDLE at edge n gives ack high after edge n+1. The channel's data reaches the output in the same cycle ack is high.
- **Release latency:** req falling (with `in_pkt=0`) is sampled at the next edge. ack falls and the next ack rises at that same edge.
- **Reset mid-packet:** grant is dropped immediately, with an asynchronous clear. The partial TLP is lost downstream; sources are responsible for discarding it.
- **Simultaneous requests at release:** the new req and the falling req are resolved by round-robin order from `g+1`. A channel never gets two consecutive grants while another channel is requesting.

## Structure
- Package `pcie_tx_arb_pkg`: state enum (IDLE/GRANT) and a `rr_next(req, last)` function.
- One sub-module: `rr_pick` (combinational round-robin priority encoder, `NUM_CH`-parameterised). Top level holds the FSM, counters and mux.

## Test plan
- **Reset, then `req=4'b0001`, 3-beat TLP:** ack[0] rises one cycle later; 3 beats appear on the output; req drops and ack returns to 0 the next cycle.
- **`req=4'b1111` held, `MAX_PKTS=0`:** grants go ch1 first. After each channel drops req in turn, grants follow 1→2→3→0 with no idle cycles.
- **ch2 drops req after beat 1 of a 4-beat TLP:** ack[2] stays high until the tlast beat is accepted, then falls.
- **`MAX_PKTS=2`, ch0 streams 1-beat TLPs, ch3 requesting:** ack[0] falls right after the 2nd tlast acceptance; ack[3] rises at the same edge.
- **`s_axis_tx_tready` toggling 1,0,1,0 during a TLP:** each beat is held until accepted; `tready[g]` mirrors tready; non-granted channels see tready=0.
- **`sys_rst` pulsed mid-TLP:** all ack, tvalid and `grant_valid` go to 0 immediately, without waiting for an edge; arbitration restarts from ch1.
